// File: rtl/fifo_drain.sv
// fifo_drain: drains a multi-port upstream fifo into a single-lane
// valid/ready stream.
//
// Up to READ contiguous lanes are pulled from the upstream fifo in one cycle.
// They go into a small buffer and are then emitted one per accepted transfer.
// The buffer refills as soon as its last entry is leaving, so a continuously
// valid upstream produces back-to-back output with no bubble.
//
// Optional feature: define FIFO_DRAIN_BYPASS_EN to present upstream lane 0
// straight to the output when the buffer is empty. Without the macro,
// out_valid and out_data come from registered state only.

`ifndef LOW
`define LOW 1'b0
`endif
`ifndef HIGH
`define HIGH 1'b1
`endif

module fifo_drain #(
    parameter int   DATA = 64,
    parameter int   READ = 4,
    parameter logic ACT  = `LOW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic [READ-1:0]      fv,
    input  logic [READ*DATA-1:0] frd,
    output logic [READ-1:0]      fre,
    output logic                 out_valid,
    output logic [DATA-1:0]      out_data,
    input  logic                 out_ready,
    output logic                 idle
);

    localparam int CW = $clog2(READ + 1);
    localparam int RW = (READ > 1) ? $clog2(READ) : 1;

    logic [DATA-1:0] entry_reg [READ];
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic [RW-1:0]   rptr_reg;
    logic [RW-1:0]   rptr_next;

    logic [READ-1:0] take;        // contiguous-from-lane-0 valid mask
    logic [CW-1:0]   k;           // number of lanes in take
    logic            fire;
    logic            load;
    logic            byp_zone;    // output driven directly from lane 0
    logic            byp_take;    // lane 0 consumed directly this cycle
    logic [READ-1:0] cap_en;
    logic [DATA-1:0] cap_data [READ];

    // Count contiguous valid lanes; anything past the first gap is ignored
    always_comb begin
        logic run;
        run  = 1'b1;
        take = '0;
        k    = '0;
        for (int i = 0; i < READ; i++) begin
            run     = run & fv[i];
            take[i] = run;
            if (run) begin
                k = k + CW'(1);
            end
        end
    end

`ifdef FIFO_DRAIN_BYPASS_EN
    assign byp_zone = (cnt_reg == '0) && !flush && reset_n;
`else
    assign byp_zone = 1'b0;
`endif

    // Output selection: buffer head, or lane 0 when bypassing an empty buffer
    always_comb begin
        if (byp_zone) begin
            out_valid = fv[0];
            out_data  = frd[DATA-1:0];
        end else begin
            out_valid = (cnt_reg != '0);
            out_data  = entry_reg[rptr_reg];
        end
    end

    assign fire     = out_valid && out_ready;
    assign byp_take = byp_zone && fire;
    assign idle     = (cnt_reg == '0);

    // Refill when empty or when the final buffered entry is leaving
    assign load = ((cnt_reg == '0) || ((cnt_reg == CW'(1)) && fire)) && !flush && reset_n;

    // Read enables: active for the contiguous lanes on a load, else inactive
    assign fre = (load ? take : '0) ^ {READ{~ACT}};

    // Capture selection: a directly consumed lane 0 shifts the rest down by one
    always_comb begin
        cap_en = '0;
        for (int i = 0; i < READ; i++) begin
            cap_data[i] = frd[i*DATA +: DATA];
        end
        if (load) begin
            if (byp_take) begin
                for (int i = 0; i < READ - 1; i++) begin
                    cap_en[i]   = take[i+1];
                    cap_data[i] = frd[(i+1)*DATA +: DATA];
                end
            end else begin
                cap_en = take;
            end
        end
    end

    // Next head pointer and occupancy
    always_comb begin
        cnt_next  = cnt_reg;
        rptr_next = rptr_reg;
        if (flush) begin
            cnt_next  = '0;
            rptr_next = '0;
        end else if (load && (k != '0)) begin
            rptr_next = '0;
            cnt_next  = byp_take ? (k - CW'(1)) : k;
        end else if (fire) begin
            cnt_next  = cnt_reg - CW'(1);
            rptr_next = (rptr_reg == RW'(READ - 1)) ? '0 : rptr_reg + RW'(1);
        end
    end

    // Occupancy and head pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg  <= '0;
            rptr_reg <= '0;
        end else begin
            cnt_reg  <= cnt_next;
            rptr_reg <= rptr_next;
        end
    end

    // Buffer entries, each written only when its lane is captured
    for (genvar gi = 0; gi < READ; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                entry_reg[gi] <= '0;
            end else if (cap_en[gi]) begin
                entry_reg[gi] <= cap_data[gi];
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain (READ=4, DATA=8, read enables active low).
// Inputs change just after the falling edge and outputs are checked 1 time
// unit later, well away from the rising edge.

`timescale 1ns/1ps

module tb_fifo_drain;

    localparam int DATA = 8;
    localparam int READ = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 flush;
    logic [READ-1:0]      fv;
    logic [READ*DATA-1:0] frd;
    logic [READ-1:0]      fre;
    logic                 out_valid;
    logic [DATA-1:0]      out_data;
    logic                 out_ready;
    logic                 idle;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_drain #(.DATA(DATA), .READ(READ), .ACT(1'b0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .fv        (fv),
        .frd       (frd),
        .fre       (fre),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic next_cycle;
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        fv        = 4'b1111;
        frd       = 32'hDDCC_BBAA;
        out_ready = 1'b0;

        // Reset state with all upstream lanes valid
        #1;
        check("rst_fre",   fre,       4'b1111);
        check("rst_valid", out_valid, 1'b0);
        check("rst_idle",  idle,      1'b1);

`ifndef FIFO_DRAIN_BYPASS_EN
        // Three contiguous lanes, drained with out_ready held high
        next_cycle;
        reset_n   = 1'b1;
        fv        = 4'b0111;
        frd       = 32'h4433_2211;
        out_ready = 1'b1;
        #1;
        check("b3_fre_load", fre,       4'b1000);
        check("b3_valid0",   out_valid, 1'b0);
        next_cycle;
        fv = 4'b0000;
        #1;
        check("b3_data0", out_data, 8'h11);
        check("b3_fre_hold", fre,   4'b1111);
        next_cycle;
        #1;
        check("b3_data1", out_data, 8'h22);
        next_cycle;
        #1;
        check("b3_data2", out_data, 8'h33);
        check("b3_valid2", out_valid, 1'b1);
        next_cycle;
        #1;
        check("b3_valid_end", out_valid, 1'b0);
        check("b3_idle_end",  idle,      1'b1);

        // Gap in fv: only lane 0 counts
        fv  = 4'b1101;
        frd = 32'h0403_025A;
        #1;
        check("gap_fre", fre, 4'b1110);
        next_cycle;
        fv = 4'b0000;
        #1;
        check("gap_data",  out_data,  8'h5A);
        check("gap_valid", out_valid, 1'b1);
        next_cycle;
        #1;
        check("gap_empty", out_valid, 1'b0);

        // Stall with two entries, then seamless reload on the last fire
        fv        = 4'b0011;
        frd       = 32'h0000_6261;
        out_ready = 1'b0;
        #1;
        check("st_fre_load", fre, 4'b1100);
        next_cycle;
        fv = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("st_data_c%0d", c), out_data, 8'h61);
            check($sformatf("st_fre_c%0d", c),  fre,      4'b1111);
            next_cycle;
        end
        out_ready = 1'b1;
        fv        = 4'b0011;
        frd       = 32'h0000_7271;
        #1;
        check("st_fire_cnt2_fre", fre,      4'b1111);
        check("st_fire_cnt2_dat", out_data, 8'h61);
        next_cycle;
        #1;
        check("st_last_dat",    out_data, 8'h62);
        check("st_reload_fre",  fre,      4'b1100);
        next_cycle;
        fv = 4'b0000;
        #1;
        check("st_nogap_valid", out_valid, 1'b1);
        check("st_new_dat0",    out_data,  8'h71);
        next_cycle;
        #1;
        check("st_new_dat1", out_data, 8'h72);
        next_cycle;
        #1;
        check("st_idle", idle, 1'b1);

        // Flush with three entries while the consumer is ready
        fv        = 4'b0111;
        frd       = 32'h0083_8281;
        out_ready = 1'b0;
        next_cycle;
        fv        = 4'b1111;
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("fl_fre",   fre,       4'b1111);
        check("fl_valid", out_valid, 1'b1);
        next_cycle;
        flush = 1'b0;
        fv    = 4'b0000;
        #1;
        check("fl_after_valid", out_valid, 1'b0);
        check("fl_after_idle",  idle,      1'b1);

        // Full load, then asynchronous reset mid-burst
        fv        = 4'b1111;
        frd       = 32'h9493_9291;
        out_ready = 1'b0;
        next_cycle;
        fv = 4'b0000;
        #1;
        check("ar_data", out_data, 8'h91);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 1'b0);
        check("ar_idle",  idle,      1'b1);
        next_cycle;
        reset_n = 1'b1;
        next_cycle;
        #1;
        check("ar_stay_empty", out_valid, 1'b0);
`else
        // Bypass: lane 0 goes straight out, lane 1 is buffered
        next_cycle;
        reset_n   = 1'b1;
        fv        = 4'b0011;
        frd       = 32'h0000_5BA5;
        out_ready = 1'b1;
        #1;
        check("by_valid", out_valid, 1'b1);
        check("by_data",  out_data,  8'hA5);
        check("by_fre",   fre,       4'b1100);
        next_cycle;
        fv = 4'b0000;
        #1;
        check("by_buf_valid", out_valid, 1'b1);
        check("by_buf_data",  out_data,  8'h5B);
        check("by_buf_idle",  idle,      1'b0);
        next_cycle;
        #1;
        check("by_empty_valid", out_valid, 1'b0);
        check("by_empty_idle",  idle,      1'b1);
        // Bypass with stalled consumer captures all lanes
        fv        = 4'b0011;
        frd       = 32'h0000_C3C2;
        out_ready = 1'b0;
        #1;
        check("by_stall_fre", fre, 4'b1100);
        next_cycle;
        fv        = 4'b0000;
        out_ready = 1'b1;
        #1;
        check("by_stall_d0", out_data, 8'hC2);
        next_cycle;
        #1;
        check("by_stall_d1", out_data, 8'hC3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
